// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and sizing helpers for the synchronous RAM-backed FIFO and
// its dual-port RAM.
//   ptr_width(aw) : width of pointers and COUNT (address bits plus a wrap bit)
//   depth(aw)     : number of RAM words for aw address bits
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH    = 9;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_AEMPTY_THRESH = 4;
  // AFULL defaults to this many words below DEPTH.
  localparam int DEF_AFULL_MARGIN  = 4;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/dual_port_ram_en.sv
// -----------------------------------------------------------------------------
// dual_port_ram_en
// Single-clock dual-port RAM: one write port, one read port, each with its own
// enable. Read-first: a read and a write to the same address on one edge
// returns the word stored before that edge. RDATA is registered and holds
// while RE is low.
//   CLK          clock, all activity on posedge
//   RST_N        asynchronous active-low reset (clears RDATA only)
//   WE/WADDR/WDATA  write port
//   RE/RADDR     read port
//   RDATA        registered read data
// -----------------------------------------------------------------------------
module dual_port_ram_en
  import fifo_pkg::*;
#(
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int data_width = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WE,
  input  logic [addr_width-1:0] WADDR,
  input  logic [data_width-1:0] WDATA,
  input  logic                  RE,
  input  logic [addr_width-1:0] RADDR,
  output logic [data_width-1:0] RDATA
);

  logic [data_width-1:0] mem [depth(addr_width)];

  // NOTE: the array has no reset branch so it maps onto block RAM; a reset
  // here would force it into flops. Callers never read a word before writing it.
  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  // NOTE: sequential state uses non-blocking assignments, so the read below
  // sees the pre-edge contents even when the write above hits the same
  // address -- that is exactly the read-first behaviour.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)  RDATA <= '0;
    else if (RE) RDATA <= mem[RADDR];
  end

endmodule

// File: rtl/fifo_sync_ram.sv
// -----------------------------------------------------------------------------
// fifo_sync_ram
// Single-clock FIFO on top of dual_port_ram_en. Owns all pointer, occupancy
// and flag logic; every output is registered.
//   CLK, RST_N           clock and asynchronous active-low reset
//   CLR                  synchronous flush (wins over same-cycle read/write)
//   DIN, WRITE_EN        write side
//   READ_EN              read request
//   DOUT, DOUT_VALID     registered read data and its one-cycle valid
//   FULL, EMPTY          COUNT == DEPTH / COUNT == 0
//   AFULL, AEMPTY        COUNT >= afull_thresh / COUNT <= aempty_thresh
//   COUNT                words stored
//   OVERFLOW, UNDERFLOW  sticky rejected-write / rejected-read flags
// -----------------------------------------------------------------------------
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int addr_width    = DEF_ADDR_WIDTH,
  parameter int data_width    = DEF_DATA_WIDTH,
  parameter int afull_thresh  = depth(addr_width) - DEF_AFULL_MARGIN,
  parameter int aempty_thresh = DEF_AEMPTY_THRESH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CLR,
  input  logic [data_width-1:0] DIN,
  input  logic                  WRITE_EN,
  input  logic                  READ_EN,
  output logic [data_width-1:0] DOUT,
  output logic                  DOUT_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic [addr_width:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int            PW         = ptr_width(addr_width);
  localparam logic [PW-1:0] DEPTH_LVL  = PW'(depth(addr_width));
  localparam logic [PW-1:0] AFULL_LVL  = PW'(afull_thresh);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(aempty_thresh);
  // Flag values for an empty FIFO, used by both reset and flush.
  localparam logic          AFULL_AT_0 = (afull_thresh == 0);

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] count_nxt;
  logic          rd_acc, wr_acc;
  logic          ram_we, ram_re;

  // NOTE: every signal here is assigned on every pass through the block, so
  // no path can leave one holding its old value and no latch is inferred.
  always_comb begin
    rd_acc    = READ_EN & ~EMPTY;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    wr_acc    = WRITE_EN & (~FULL | rd_acc);
    // Flush suppresses RAM traffic so DOUT holds and nothing is stored.
    ram_re    = rd_acc & ~CLR;
    ram_we    = wr_acc & ~CLR;
    count_nxt = COUNT + PW'(wr_acc) - PW'(rd_acc);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr       <= '0;
      rptr       <= '0;
      COUNT      <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      AFULL      <= AFULL_AT_0;
      AEMPTY     <= 1'b1;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
      DOUT_VALID <= 1'b0;
    end else if (CLR) begin
      wptr       <= '0;
      rptr       <= '0;
      COUNT      <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      AFULL      <= AFULL_AT_0;
      AEMPTY     <= 1'b1;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
      DOUT_VALID <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) rptr <= rptr + PW'(1);
      // Flags are derived from the next count so they line up with COUNT.
      COUNT      <= count_nxt;
      FULL       <= (count_nxt == DEPTH_LVL);
      EMPTY      <= (count_nxt == '0);
      AFULL      <= (count_nxt >= AFULL_LVL);
      AEMPTY     <= (count_nxt <= AEMPTY_LVL);
      if (WRITE_EN & ~wr_acc) OVERFLOW  <= 1'b1;
      if (READ_EN & EMPTY)    UNDERFLOW <= 1'b1;
      DOUT_VALID <= rd_acc;
    end
  end

  dual_port_ram_en #(
    .addr_width (addr_width),
    .data_width (data_width)
  ) u_ram (
    .CLK   (CLK),
    .RST_N (RST_N),
    .WE    (ram_we),
    .WADDR (wptr[addr_width-1:0]),
    .WDATA (DIN),
    .RE    (ram_re),
    .RADDR (rptr[addr_width-1:0]),
    .RDATA (DOUT)
  );

endmodule

// File: tb/tb_fifo_sync_ram.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_ram
// Self-checking bench for fifo_sync_ram (default 512 x 8). A queue-based model
// tracks contents, DOUT and sticky flags; a compare process checks all outputs
// on every falling edge, and directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_fifo_sync_ram;

  localparam int AW       = 9;
  localparam int DW       = 8;
  localparam int DEPTH    = 512;
  localparam int AFULL_T  = DEPTH - 4;
  localparam int AEMPTY_T = 4;

  logic          CLK      = 1'b0;
  logic          RST_N    = 1'b0;
  logic          CLR      = 1'b0;
  logic [DW-1:0] DIN      = '0;
  logic          WRITE_EN = 1'b0;
  logic          READ_EN  = 1'b0;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
  logic [AW:0]   COUNT;

  fifo_sync_ram dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CLR        (CLR),
    .DIN        (DIN),
    .WRITE_EN   (WRITE_EN),
    .READ_EN    (READ_EN),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .AFULL      (AFULL),
    .AEMPTY     (AEMPTY),
    .COUNT      (COUNT),
    .OVERFLOW   (OVERFLOW),
    .UNDERFLOW  (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_dv   = 1'b0;
  bit            m_ovf  = 1'b0;
  bit            m_unf  = 1'b0;
  int            wr_total = 0;
  int            m_n;
  bit            m_rd, m_wr;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (CLR) begin
      q.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_n  = q.size();
      m_rd = READ_EN && (m_n != 0);
      m_wr = WRITE_EN && ((m_n != DEPTH) || m_rd);
      if (READ_EN && m_n == 0) m_unf = 1'b1;
      if (WRITE_EN && !m_wr)   m_ovf = 1'b1;
      // Pop before push: a same-cycle read returns the oldest word, never DIN.
      if (m_rd) m_dout = q.pop_front();
      m_dv = m_rd;
      if (m_wr) begin
        q.push_back(DIN);
        wr_total++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en && RST_N) begin
      check("count",      COUNT,      q.size());
      check("full",       FULL,       q.size() == DEPTH);
      check("empty",      EMPTY,      q.size() == 0);
      check("afull",      AFULL,      q.size() >= AFULL_T);
      check("aempty",     AEMPTY,     q.size() <= AEMPTY_T);
      check("overflow",   OVERFLOW,   m_ovf);
      check("underflow",  UNDERFLOW,  m_unf);
      check("dout_valid", DOUT_VALID, m_dv);
      check("dout",       DOUT,       m_dout);
    end
  end

  // One clock: drive on the falling edge, let the rising edge sample, then
  // return to idle inputs 1 ns later so directed checks can look at outputs.
  task automatic step(input bit we, input bit re, input bit clr, input logic [DW-1:0] din);
    @(negedge CLK);
    WRITE_EN = we;
    READ_EN  = re;
    CLR      = clr;
    DIN      = din;
    @(posedge CLK);
    #1;
    WRITE_EN = 1'b0;
    READ_EN  = 1'b0;
    CLR      = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},  COUNT,      0);
    check({tag, "_empty"},  EMPTY,      1);
    check({tag, "_full"},   FULL,       0);
    check({tag, "_afull"},  AFULL,      0);
    check({tag, "_aempty"}, AEMPTY,     1);
    check({tag, "_dout"},   DOUT,       0);
    check({tag, "_dv"},     DOUT_VALID, 0);
    check({tag, "_ovf"},    OVERFLOW,   0);
    check({tag, "_unf"},    UNDERFLOW,  0);
  endtask

  bit r_we, r_re, wr_heavy;

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N  = 1'b1;
    chk_en = 1'b1;
    #1;
    check_reset_values("rst");

    // Five writes then five reads.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, DW'(i + 1));
      check("wr5_count",  COUNT,  i + 1);
      check("wr5_aempty", AEMPTY, (i + 1) <= 4);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check("rd5_dout",   DOUT,       i + 1);
      check("rd5_valid",  DOUT_VALID, 1);
      check("rd5_count",  COUNT,      4 - i);
      check("rd5_aempty", AEMPTY,     1);
    end
    check("rd5_empty", EMPTY, 1);

    // Fill to DEPTH.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, DW'(i) ^ 8'hA5);
      if (i == 506) check("fill_afull_507", AFULL, 0);
      if (i == 507) check("fill_afull_508", AFULL, 1);
      if (i == 510) check("fill_full_511",  FULL,  0);
    end
    check("fill_full",  FULL,  1);
    check("fill_count", COUNT, 512);

    // Simultaneous read/write while full: read-first, no overflow.
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    check("full_rw_dout",  DOUT,       8'hA5);
    check("full_rw_valid", DOUT_VALID, 1);
    check("full_rw_count", COUNT,      512);
    check("full_rw_ovf",   OVERFLOW,   0);

    // Write while full with no read: rejected.
    step(1'b1, 1'b0, 1'b0, 8'h11);
    check("ovf_flag",  OVERFLOW, 1);
    check("ovf_count", COUNT,    512);

    step(1'b0, 1'b0, 1'b1, '0);
    check("clr1_empty", EMPTY,    1);
    check("clr1_ovf",   OVERFLOW, 0);

    // Read+write while empty: write only, underflow set.
    step(1'b1, 1'b1, 1'b0, 8'h5C);
    check("unf_flag",  UNDERFLOW,  1);
    check("unf_count", COUNT,      1);
    check("unf_valid", DOUT_VALID, 0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("unf_rd_dout",  DOUT,       8'h5C);
    check("unf_rd_valid", DOUT_VALID, 1);
    step(1'b0, 1'b0, 1'b1, '0);

    // Random traffic in long write-heavy / read-heavy phases so occupancy
    // sweeps between empty and full and the pointers wrap several times.
    wr_total = 0;
    for (int c = 0; c < 4000; c++) begin
      wr_heavy = ((c / 700) % 2) == 0;
      r_we = $urandom_range(0, 99) < (wr_heavy ? 95 : 20);
      r_re = $urandom_range(0, 99) < (wr_heavy ? 20 : 95);
      step(r_we, r_re, 1'b0, DW'($urandom));
    end
    check("rand_wraps", wr_total >= 2 * DEPTH, 1);

    // Flush at COUNT 7 with READ_EN high.
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("pre_clr_unf", UNDERFLOW, 1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h30 + i));
    check("pre_clr_count", COUNT, 7);
    step(1'b0, 1'b1, 1'b1, '0);
    check("clr_count", COUNT,      0);
    check("clr_empty", EMPTY,      1);
    check("clr_valid", DOUT_VALID, 0);
    check("clr_unf",   UNDERFLOW,  0);
    check("clr_ovf",   OVERFLOW,   0);

    // Asynchronous reset in the middle of a burst.
    step(1'b1, 1'b0, 1'b0, 8'h41);
    step(1'b1, 1'b0, 1'b0, 8'h42);
    step(1'b1, 1'b1, 1'b0, 8'h43);
    @(negedge CLK);
    WRITE_EN = 1'b1;
    DIN      = 8'h44;
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_values("arst");
    WRITE_EN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h77);
    check("post_rst_count", COUNT, 1);
    step(1'b0, 1'b1, 1'b0, '0);
    check("post_rst_dout",  DOUT,  8'h77);
    check("post_rst_empty", EMPTY, 1);

    step(1'b0, 1'b0, 1'b0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
